// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing generator.
// A clock divider makes the pixel enable; one horizontal/vertical counter pair
// produces the pixel coordinate, and the sync and blanking flags are
// registered from the counters' next-state values. This keeps every output
// aligned to the same pixel.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_end
);

  // Both totals must fit the 10-bit coordinate registers (<= 1024).
  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             h_last;
  logic             v_last;

  // Inclusive range test used for the sync pulse windows.
  function automatic logic in_window(input logic [9:0] val, input int lo, input int hi);
    return (int'(val) >= lo) && (int'(val) <= hi);
  endfunction

  assign p_tick    = (div == DIV_W'(CLK_DIV - 1));
  assign h_last    = (pixel_x == 10'(H_TOTAL - 1));
  assign v_last    = (pixel_y == 10'(V_TOTAL - 1));
  assign line_end  = p_tick && h_last;
  assign frame_end = line_end && v_last;

  // Pixel enable divider: wraps after CLK_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (p_tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Next coordinate: advance on a tick, carry into the line count at line end.
  always_comb begin
    h_next = pixel_x;
    v_next = pixel_y;
    if (p_tick) begin
      if (h_last) begin
        h_next = '0;
        v_next = v_last ? '0 : pixel_y + 10'd1;
      end else begin
        h_next = pixel_x + 10'd1;
      end
    end
  end

  // Coordinate registers plus flags decoded from the next coordinate so that
  // the flags change on the same edge as pixel_x/pixel_y.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x  <= '0;
      pixel_y  <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else begin
      pixel_x  <= h_next;
      pixel_y  <= v_next;
      hsync    <= !in_window(h_next, HS_START, HS_END);
      vsync    <= !in_window(v_next, VS_START, VS_END);
      video_on <= (h_next < 10'(H_DISPLAY)) && (v_next < 10'(V_DISPLAY));
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen.
// Instance a uses the default 640x480 geometry for the line-level checks.
// Instance b uses a tiny geometry so that full frames, wrap-around and
// mid-frame reset fit in a short run. Its geometry is:
//   CLK_DIV 3, H 6/2/3/1 (total 12, hsync low x 8..10),
//   V 4/1/2/2 (total 9, vsync low y 5..6), frame 324 clks.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst_a;
  logic       rst_b;
  logic       a_tick, a_von, a_hs, a_vs, a_le, a_fe;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_von, b_hs, b_vs, b_le, b_fe;
  logic [9:0] b_x, b_y;

  int checks = 0;
  int errors = 0;

  // measurements gathered by the run tasks
  int hs_low_cnt, tick_cnt, le_cnt, le_pos;
  int vs_low_cnt, fe_cnt, fe_first, fe_second;

  always #5 clk = ~clk;

  vga_sync_gen dut_a (
    .clk(clk), .rst(rst_a), .p_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
    .video_on(a_von), .hsync(a_hs), .vsync(a_vs),
    .line_end(a_le), .frame_end(a_fe)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_DISPLAY(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_b (
    .clk(clk), .rst(rst_b), .p_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
    .video_on(b_von), .hsync(b_hs), .vsync(b_vs),
    .line_end(b_le), .frame_end(b_fe)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_x"}, 32'(a_x), 0);
    chk({tag, "_y"}, 32'(a_y), 0);
    chk({tag, "_tick"}, 32'(a_tick), 0);
    chk({tag, "_hsync"}, 32'(a_hs), 1);
    chk({tag, "_vsync"}, 32'(a_vs), 1);
    chk({tag, "_von"}, 32'(a_von), 0);
    chk({tag, "_le"}, 32'(a_le), 0);
    chk({tag, "_fe"}, 32'(a_fe), 0);
  endtask

  task automatic chk_reset_b(input string tag);
    chk({tag, "_x"}, 32'(b_x), 0);
    chk({tag, "_y"}, 32'(b_y), 0);
    chk({tag, "_tick"}, 32'(b_tick), 0);
    chk({tag, "_hsync"}, 32'(b_hs), 1);
    chk({tag, "_vsync"}, 32'(b_vs), 1);
    chk({tag, "_von"}, 32'(b_von), 0);
    chk({tag, "_le"}, 32'(b_le), 0);
    chk({tag, "_fe"}, 32'(b_fe), 0);
  endtask

  // Instance a, n cycles after reset release. k counts edges since release.
  task automatic run_a(input int n);
    int ex, ey, et, ehs;
    hs_low_cnt = 0; tick_cnt = 0; le_cnt = 0; le_pos = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      ex  = (k / 4) % 800;
      ey  = k / 3200;
      et  = (k % 4 == 3) ? 1 : 0;
      ehs = (ex >= 656 && ex <= 751) ? 0 : 1;
      chk("a_x", 32'(a_x), ex);
      chk("a_y", 32'(a_y), ey);
      chk("a_tick", 32'(a_tick), et);
      chk("a_von", 32'(a_von), (ex < 640 && ey < 480) ? 1 : 0);
      chk("a_hsync", 32'(a_hs), ehs);
      chk("a_vsync", 32'(a_vs), 1);
      chk("a_le", 32'(a_le), (et == 1 && ex == 799) ? 1 : 0);
      chk("a_fe", 32'(a_fe), 0);
      if (k <= 3200) begin
        if (a_hs === 1'b0) hs_low_cnt++;
        if (a_tick === 1'b1) tick_cnt++;
        if (a_le === 1'b1) begin le_cnt++; le_pos = k; end
      end
    end
  endtask

  // Instance b, n cycles after reset release.
  task automatic run_b(input int n);
    int ex, ey, et;
    vs_low_cnt = 0; fe_cnt = 0; fe_first = -1; fe_second = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      ex = (k / 3) % 12;
      ey = (k / 36) % 9;
      et = (k % 3 == 2) ? 1 : 0;
      chk("b_x", 32'(b_x), ex);
      chk("b_y", 32'(b_y), ey);
      chk("b_tick", 32'(b_tick), et);
      chk("b_von", 32'(b_von), (ex < 6 && ey < 4) ? 1 : 0);
      chk("b_hsync", 32'(b_hs), (ex >= 8 && ex <= 10) ? 0 : 1);
      chk("b_vsync", 32'(b_vs), (ey >= 5 && ey <= 6) ? 0 : 1);
      chk("b_le", 32'(b_le), (et == 1 && ex == 11) ? 1 : 0);
      chk("b_fe", 32'(b_fe), (et == 1 && ex == 11 && ey == 8) ? 1 : 0);
      if (k <= 324 && b_vs === 1'b0) vs_low_cnt++;
      if (b_fe === 1'b1) begin
        fe_cnt++;
        if (fe_first < 0) fe_first = k;
        else if (fe_second < 0) fe_second = k;
      end
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_a("a_por");

    // free-run briefly, then a 3-cycle reset at an arbitrary point
    rst_a = 1'b0;
    repeat (37) @(negedge clk);
    rst_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_reset_a("a_rst3");
    end
    rst_a = 1'b0;

    // one full line plus a few clocks into line 1
    run_a(3208);
    chk("a_hs_low_clks", 32'(hs_low_cnt), 384);
    chk("a_ticks_per_line", 32'(tick_cnt), 800);
    chk("a_le_count", 32'(le_cnt), 1);
    chk("a_le_pos", 32'(le_pos), 3199);
    rst_a = 1'b1;

    // tiny geometry: two frames from reset
    @(negedge clk);
    chk_reset_b("b_por");
    rst_b = 1'b0;
    run_b(653);
    chk("b_vs_low_clks", 32'(vs_low_cnt), 72);
    chk("b_fe_count", 32'(fe_cnt), 2);
    chk("b_fe_first", 32'(fe_first), 323);
    chk("b_frame_period", 32'(fe_second - fe_first), 324);

    // mid-frame reset while hsync and vsync are both low, at (9,6)
    rst_b = 1'b1;
    @(negedge clk);
    chk_reset_b("b_rst_a");
    rst_b = 1'b0;
    run_b(245);
    chk("b_mid_x", 32'(b_x), 9);
    chk("b_mid_y", 32'(b_y), 6);
    chk("b_mid_hs", 32'(b_hs), 0);
    chk("b_mid_vs", 32'(b_vs), 0);
    rst_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_reset_b("b_mid_rst");
    end
    rst_b = 1'b0;
    run_b(330);
    chk("b_re_fe_first", 32'(fe_first), 323);
    chk("b_re_fe_count", 32'(fe_cnt), 1);
    chk("b_re_vs_low_clks", 32'(vs_low_cnt), 72);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
